// File: rtl/jump_target_ras_if.sv
// Bundle between the ID-stage jump unit and its surroundings: decode inputs,
// registered jump/prediction results and return-address-stack occupancy.
interface jump_target_ras_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAS_DEPTH  = 8
);
  localparam int PTR_WIDTH = $clog2(RAS_DEPTH);

  logic [31:0]           Instruction;
  logic                  InstrValid;
  logic [ADDR_WIDTH-1:0] PCResult;
  logic [ADDR_WIDTH-1:0] JumpRegister;
  logic                  Stall;
  logic                  Flush;
  logic [ADDR_WIDTH-1:0] JumpAddress;
  logic                  JumpTaken;
  logic [ADDR_WIDTH-1:0] PredictAddress;
  logic                  PredictValid;
  logic                  Mispredict;
  logic [PTR_WIDTH:0]    RasCount;
  logic                  RasEmpty;
  logic                  RasFull;

  modport master (
    output Instruction, InstrValid, PCResult, JumpRegister, Stall, Flush,
    input  JumpAddress, JumpTaken, PredictAddress, PredictValid, Mispredict,
    input  RasCount, RasEmpty, RasFull
  );

  modport slave (
    input  Instruction, InstrValid, PCResult, JumpRegister, Stall, Flush,
    output JumpAddress, JumpTaken, PredictAddress, PredictValid, Mispredict,
    output RasCount, RasEmpty, RasFull
  );
endinterface

// File: rtl/jump_target_ras.sv
// ID-stage jump target computation with a circular return-address stack that
// predicts jr $ra targets and flags mispredicts one cycle after decode.
module jump_target_ras #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAS_DEPTH  = 8
) (
  input logic              Clk,
  input logic              Reset,
  jump_target_ras_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(RAS_DEPTH);
  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH+1)'(RAS_DEPTH);
  localparam logic [PTR_WIDTH:0]   ZERO_COUNT = (PTR_WIDTH+1)'(0);
  localparam logic [PTR_WIDTH:0]   COUNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);
  localparam logic [4:0]           RA_REG     = 5'd31;

  typedef enum logic [2:0] {
    DEC_NONE = 3'd0,
    DEC_J    = 3'd1,
    DEC_JAL  = 3'd2,
    DEC_JR   = 3'd3,
    DEC_JALR = 3'd4
  } dec_e;

  logic [ADDR_WIDTH-1:0] ras_r [RAS_DEPTH];
  logic [PTR_WIDTH-1:0]  ptr_r;
  logic [PTR_WIDTH:0]    count_r;
  logic [ADDR_WIDTH-1:0] jump_addr_r;
  logic                  jump_taken_r;
  logic [ADDR_WIDTH-1:0] pred_addr_r;
  logic                  pred_valid_r;
  logic                  mispredict_r;

  logic [5:0]            op_s;
  logic [5:0]            funct_s;
  logic [4:0]            rs_s;
  dec_e                  kind_s;
  logic                  is_jump_s;
  logic [ADDR_WIDTH-1:0] target_s;
  logic                  push_s;
  logic                  pop_s;
  logic [PTR_WIDTH-1:0]  top_idx_s;
  logic [ADDR_WIDTH-1:0] top_val_s;
  logic [PTR_WIDTH-1:0]  wr_idx_s;
  logic [PTR_WIDTH-1:0]  ptr_next_s;
  logic [PTR_WIDTH:0]    count_next_s;

  assign op_s    = bus.Instruction[31:26];
  assign funct_s = bus.Instruction[5:0];
  assign rs_s    = bus.Instruction[25:21];

  // Instruction class decode; flushed or invalid slots decode as no jump.
  always_comb begin
    kind_s = DEC_NONE;
    if (bus.InstrValid && !bus.Flush) begin
      case (op_s)
        6'b000010: kind_s = DEC_J;
        6'b000011: kind_s = DEC_JAL;
        6'b000000: begin
          case (funct_s)
            6'b001000: kind_s = DEC_JR;
            6'b001001: kind_s = DEC_JALR;
            default:   kind_s = DEC_NONE;
          endcase
        end
        default:   kind_s = DEC_NONE;
      endcase
    end else begin
      kind_s = DEC_NONE;
    end
  end

  // Target selection and stack pointer/count next-state.
  always_comb begin
    target_s        = bus.PCResult;
    target_s[27:0]  = {bus.Instruction[25:0], 2'b00};
    if (kind_s == DEC_JR || kind_s == DEC_JALR) begin
      target_s = bus.JumpRegister;
    end else begin
      target_s = target_s;
    end
    is_jump_s    = (kind_s != DEC_NONE);
    push_s       = (kind_s == DEC_JAL) || (kind_s == DEC_JALR);
    pop_s        = ((kind_s == DEC_JR) || (kind_s == DEC_JALR)) && (rs_s == RA_REG)
                   && (count_r != ZERO_COUNT);
    top_idx_s    = ptr_r - PTR_ONE;
    top_val_s    = ras_r[top_idx_s];
    wr_idx_s     = ptr_r;
    ptr_next_s   = ptr_r;
    count_next_s = count_r;
    // A jalr $ra pops the old top and then reuses that slot for its own link.
    if (pop_s && push_s) begin
      wr_idx_s = top_idx_s;
    end else if (pop_s) begin
      ptr_next_s   = top_idx_s;
      count_next_s = count_r - COUNT_ONE;
    end else if (push_s) begin
      ptr_next_s   = ptr_r + PTR_ONE;
      count_next_s = (count_r == FULL_COUNT) ? count_r : count_r + COUNT_ONE;
    end else begin
      ptr_next_s   = ptr_r;
      count_next_s = count_r;
    end
  end

  // Stack storage; contents are never observed before being written.
  always_ff @(posedge Clk) begin
    if (!bus.Stall && push_s) begin
      ras_r[wr_idx_s] <= bus.PCResult;
    end
  end

  // Registered results and stack bookkeeping; Stall freezes everything.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ptr_r        <= '0;
      count_r      <= '0;
      jump_addr_r  <= '0;
      jump_taken_r <= 1'b0;
      pred_addr_r  <= '0;
      pred_valid_r <= 1'b0;
      mispredict_r <= 1'b0;
    end else if (!bus.Stall) begin
      ptr_r        <= ptr_next_s;
      count_r      <= count_next_s;
      jump_taken_r <= is_jump_s;
      pred_valid_r <= pop_s;
      mispredict_r <= pop_s && (top_val_s != target_s);
      if (is_jump_s) begin
        jump_addr_r <= target_s;
      end
      if (pop_s) begin
        pred_addr_r <= top_val_s;
      end
    end
  end

  assign bus.JumpAddress    = jump_addr_r;
  assign bus.JumpTaken      = jump_taken_r;
  assign bus.PredictAddress = pred_addr_r;
  assign bus.PredictValid   = pred_valid_r;
  assign bus.Mispredict     = mispredict_r;
  assign bus.RasCount       = count_r;
  assign bus.RasEmpty       = (count_r == ZERO_COUNT);
  assign bus.RasFull        = (count_r == FULL_COUNT);
endmodule

// File: doc/jump_target_ras.md
Name: jump_target_ras

Overview:
Parametrised jump-target unit for the ID stage with a return-address stack (RAS).
- Decodes j, jal, jr and jalr and computes the jump target.
- Pushes return addresses on jal/jalr.
- Pops a predicted return address on jr $ra and flags a mispredict against the resolved register value.
- Outputs are registered one cycle and feed the PC-select mux and hazard/flush logic.

Parameters:
ADDR_WIDTH, 32, PC/target width; must be >= 28.
RAS_DEPTH, 8, number of RAS entries; power of two, >= 2.
PTR_WIDTH, $clog2(RAS_DEPTH), RAS pointer width (derived, do not override).

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
Instruction  input  32  instruction in ID.
InstrValid  input  1  Instruction is valid this cycle.
PCResult  input  ADDR_WIDTH  PC+4 of the instruction.
JumpRegister  input  ADDR_WIDTH  forwarded rs value.
Stall  input  1  hold all registered state.
Flush  input  1  squash the current instruction.
JumpAddress  output  ADDR_WIDTH  registered jump target.
JumpTaken  output  1  registered: JumpAddress is valid for one cycle.
PredictAddress  output  ADDR_WIDTH  registered RAS top popped by jr $ra.
PredictValid  output  1  PredictAddress is meaningful.
Mispredict  output  1  PredictValid and PredictAddress != JumpAddress.
RasCount  output  PTR_WIDTH+1  live entries, 0..RAS_DEPTH.
RasEmpty  output  1  RasCount == 0.
RasFull  output  1  RasCount == RAS_DEPTH.

Behaviour:
- Reset low (asynchronous): all outputs 0, RAS pointer 0, count 0, RAS contents don't-care. Release is synchronous to the next Clk edge.
- Decode is active only when InstrValid=1, Flush=0 and Stall=0:
  - j: op=000010.
  - jal: op=000011.
  - jr: op=000000, funct=001000.
  - jalr: op=000000, funct=001001.
  - Any other encoding is "no jump".
- Targets:
  - j/jal: {PCResult[ADDR_WIDTH-1:28], Instruction[25:0], 2'b00}.
  - jr/jalr: JumpRegister.
- Latency: one cycle. Decode in cycle N produces JumpTaken=1 with JumpAddress in cycle N+1. JumpTaken is a single-cycle pulse.
- No jump: JumpTaken=0, PredictValid=0, Mispredict=0. JumpAddress holds its last value.
- Push occurs on jal or jalr: value PCResult.
  - Write entry [ptr], then ptr = ptr+1 mod RAS_DEPTH.
  - Count increments, saturating at RAS_DEPTH.
  - When full, the push overwrites the oldest entry (circular buffer); count stays at RAS_DEPTH.
- Pop occurs on jr, or jalr, with rs (Instruction[25:21]) == 31:
  - Count > 0: PredictAddress = entry[ptr-1], PredictValid=1, ptr = ptr-1, count-1.
  - Count == 0: PredictValid=0, no pointer change, count stays 0. PredictAddress holds.
- jalr with rs=31 does both pop and push in the same cycle:
  - Pop reads the old top, then the push writes PCResult into the same slot.
  - Net pointer and count are unchanged.
  - If count was 0: push only, count becomes 1.
- Mispredict is registered together with JumpTaken; it is asserted only when PredictValid=1 and the addresses differ (full-width compare).
- Stall=1: all registers hold, including JumpTaken, PredictValid and Mispredict. No push or pop.
- Flush=1 with Stall=0: the current instruction is ignored (no push/pop); JumpTaken, PredictValid and Mispredict go to 0 next cycle.
- Stall and Flush both high: Stall wins.
- RasEmpty and RasFull are combinational from the count register.

Test Plan:
- Reset then j: PCResult=0x00400004, Instruction=0x08100010 -> next cycle JumpTaken=1, JumpAddress=0x00400040; the following cycle JumpTaken=0.
- jal then jr $ra: jal (0x0C100020) at PCResult=0x00400008 -> RasCount=1. Then jr $ra (0x03E00008) with JumpRegister=0x00400008 -> PredictValid=1, PredictAddress=0x00400008, Mispredict=0, RasCount=0.
- Mispredict: push 0x00400010, then jr $ra with JumpRegister=0x00400100 -> Mispredict=1, JumpAddress=0x00400100.
- Overflow and underflow: 9 jal with RAS_DEPTH=8 -> RasFull=1, RasCount=8. Then 9 jr $ra -> the first 8 pops return the last 8 pushes in LIFO order; the 9th gives PredictValid=0, RasEmpty=1.
- Stall/Flush: jal presented with Stall=1 for 3 cycles -> no count change, outputs held. jal with Flush=1 -> RasCount unchanged, JumpTaken=0.
- Async reset mid-operation: assert Reset=0 between clock edges with RasCount=3 -> outputs and RasCount go to 0 immediately, without waiting for Clk.
